// File: rtl/rf_write_packer_32to64.sv
// Packs 32-bit half-word writes into 64-bit register-file writes, falling back to read-modify-write.
// Optional event counters are compiled in with `define RF_WRITE_PACKER_STATS_EN.
module rf_write_packer_32to64 #(
  parameter int unsigned WADDR_WIDTH  = 5,
  parameter int unsigned RADDR_WIDTH  = WADDR_WIDTH + 1,
  parameter int unsigned HOLD_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [RADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]            req_data_i,
  input  logic                   flush_i,
  output logic                   busy_o,
  output logic                   rf_we_o,
  output logic [WADDR_WIDTH-1:0] rf_waddr_o,
  output logic [63:0]            rf_wdata_o,
  output logic                   rf_re_o,
  output logic [RADDR_WIDTH-1:0] rf_raddr_o,
  input  logic [31:0]            rf_rdata_i
`ifdef RF_WRITE_PACKER_STATS_EN
  ,
  input  logic                   stat_clr_i,
  output logic [15:0]            stat_pair_o,
  output logic [15:0]            stat_rmw_o
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_RD    = 2'd2;
  localparam logic [1:0] S_MERGE = 2'd3;

  localparam int unsigned   CNT_W    = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TIMEOUT - 1);

  logic [1:0]             state_q, state_d;
  logic [WADDR_WIDTH-1:0] hw_q, hw_d;
  logic                   hh_q, hh_d;
  logic [31:0]            hd_q, hd_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic [WADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [63:0]            wdata_q, wdata_d;
  logic [RADDR_WIDTH-1:0] raddr_q, raddr_d;

  logic [WADDR_WIDTH-1:0] req_w;
  logic                   req_h;
  logic                   ready_c;
  logic                   accept_c;
  logic                   pair_wr_c;
  logic                   rmw_wr_c;

  assign req_w = WADDR_WIDTH'(req_addr_i[RADDR_WIDTH-1:1]);
  assign req_h = req_addr_i[0];

  // A held half only accepts further requests that target the same word.
  always_comb begin
    ready_c = 1'b0;
    case (state_q)
      S_IDLE:  ready_c = 1'b1;
      S_HOLD:  ready_c = (req_w == hw_q);
      default: ready_c = 1'b0;
    endcase
  end

  assign req_ready_o = rst_n & ready_c;
  assign accept_c    = req_valid_i & req_ready_o;

  always_comb begin
    state_d   = state_q;
    hw_d      = hw_q;
    hh_d      = hh_q;
    hd_d      = hd_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    raddr_d   = raddr_q;
    pair_wr_c = 1'b0;
    rmw_wr_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          hw_d    = req_w;
          hh_d    = req_h;
          hd_d    = req_data_i;
          cnt_d   = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (accept_c) begin
          if (req_h != hh_q) begin
            we_d      = 1'b1;
            waddr_d   = hw_q;
            wdata_d   = hh_q ? {hd_q, req_data_i} : {req_data_i, hd_q};
            pair_wr_c = 1'b1;
            state_d   = S_IDLE;
          end else begin
            hd_d  = req_data_i;
            cnt_d = '0;
          end
        end else if (req_valid_i || flush_i || (cnt_q == CNT_LAST)) begin
          // Fetch the missing half of the held word.
          raddr_d = RADDR_WIDTH'({hw_q, ~hh_q});
          state_d = S_RD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD: begin
        state_d = S_MERGE;
      end
      S_MERGE: begin
        we_d     = 1'b1;
        waddr_d  = hw_q;
        wdata_d  = hh_q ? {hd_q, rf_rdata_i} : {rf_rdata_i, hd_q};
        rmw_wr_c = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hw_q    <= '0;
      hh_q    <= 1'b0;
      hd_q    <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      hw_q    <= hw_d;
      hh_q    <= hh_d;
      hd_q    <= hd_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      raddr_q <= raddr_d;
    end
  end

  assign rf_we_o    = we_q;
  assign rf_waddr_o = waddr_q;
  assign rf_wdata_o = wdata_q;
  assign rf_re_o    = (state_q == S_RD);
  assign rf_raddr_o = raddr_q;
  assign busy_o     = (state_q != S_IDLE) | we_q;

`ifdef RF_WRITE_PACKER_STATS_EN
  logic [15:0] stat_pair_q, stat_pair_d;
  logic [15:0] stat_rmw_q, stat_rmw_d;

  // Saturating event counters; clear wins over a same-cycle increment.
  always_comb begin
    stat_pair_d = stat_pair_q;
    stat_rmw_d  = stat_rmw_q;
    if (stat_clr_i) begin
      stat_pair_d = '0;
      stat_rmw_d  = '0;
    end else begin
      if (pair_wr_c && (stat_pair_q != 16'hFFFF)) stat_pair_d = stat_pair_q + 16'd1;
      if (rmw_wr_c && (stat_rmw_q != 16'hFFFF))   stat_rmw_d  = stat_rmw_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_pair_q <= '0;
      stat_rmw_q  <= '0;
    end else begin
      stat_pair_q <= stat_pair_d;
      stat_rmw_q  <= stat_rmw_d;
    end
  end

  assign stat_pair_o = stat_pair_q;
  assign stat_rmw_o  = stat_rmw_q;
`else
  logic unused_c;
  assign unused_c = pair_wr_c ^ rmw_wr_c;
`endif

endmodule

// File: tb/tb_rf_write_packer_32to64.sv
// Bench for rf_write_packer_32to64: register-file model plus an ideal half-word memory
// that every accepted request updates; the packed writes must reproduce that memory.
module tb_rf_write_packer_32to64;

  localparam int unsigned WADDR_WIDTH  = 5;
  localparam int unsigned RADDR_WIDTH  = 6;
  localparam int unsigned HOLD_TIMEOUT = 16;
  localparam int unsigned NWORDS       = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [5:0]  req_addr_i = '0;
  logic [31:0] req_data_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [63:0] rf_wdata_o;
  logic        rf_re_o;
  logic [5:0]  rf_raddr_o;
  logic [31:0] rf_rdata_i = '0;
`ifdef RF_WRITE_PACKER_STATS_EN
  logic        stat_clr_i = 1'b0;
  logic [15:0] stat_pair_o;
  logic [15:0] stat_rmw_o;
`endif

  always #5 clk = ~clk;

  rf_write_packer_32to64 #(
    .WADDR_WIDTH (WADDR_WIDTH),
    .RADDR_WIDTH (RADDR_WIDTH),
    .HOLD_TIMEOUT(HOLD_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i (req_addr_i),
    .req_data_i (req_data_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .rf_we_o    (rf_we_o),
    .rf_waddr_o (rf_waddr_o),
    .rf_wdata_o (rf_wdata_o),
    .rf_re_o    (rf_re_o),
    .rf_raddr_o (rf_raddr_o),
    .rf_rdata_i (rf_rdata_i)
`ifdef RF_WRITE_PACKER_STATS_EN
    ,
    .stat_clr_i (stat_clr_i),
    .stat_pair_o(stat_pair_o),
    .stat_rmw_o (stat_rmw_o)
`endif
  );

  logic [63:0] rf_mem [NWORDS];
  logic [31:0] ideal  [2*NWORDS];
  int          n_we = 0;
  int          n_re = 0;
  logic [4:0]  last_waddr = '0;
  logic [63:0] last_wdata = '0;
  logic        load_en = 1'b0;
  logic [4:0]  load_word = '0;
  logic [63:0] load_val = '0;
  logic        resync_en = 1'b0;
  int          tests_run = 0;
  int          tests_failed = 0;

  // Register file, its read port, and the ideal memory; the only writer of these arrays.
  always @(posedge clk) begin
    if (load_en) begin
      rf_mem[load_word] <= load_val;
    end else if (rf_we_o) begin
      rf_mem[rf_waddr_o] <= rf_wdata_o;
      last_waddr <= rf_waddr_o;
      last_wdata <= rf_wdata_o;
    end
    if (rf_we_o) n_we <= n_we + 1;
    if (rf_re_o) begin
      rf_rdata_i <= rf_raddr_o[0] ? rf_mem[rf_raddr_o[5:1]][63:32] : rf_mem[rf_raddr_o[5:1]][31:0];
      n_re <= n_re + 1;
    end
    if (resync_en) begin
      for (int i = 0; i < int'(NWORDS); i++) begin
        ideal[2*i]   <= rf_mem[i][31:0];
        ideal[2*i+1] <= rf_mem[i][63:32];
      end
    end else if (req_valid_i && req_ready_o) begin
      ideal[req_addr_i] <= req_data_i;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word_val(input logic [4:0] w, input logic [63:0] v);
    load_en = 1'b1; load_word = w; load_val = v;
    tick();
    load_en = 1'b0;
    resync_en = 1'b1;
    tick();
    resync_en = 1'b0;
  endtask

  task automatic send(input logic [5:0] a, input logic [31:0] d, output int waited);
    req_valid_i = 1'b1; req_addr_i = a; req_data_i = d; waited = 0;
    #1;
    while (!req_ready_o && waited < 64) begin
      tick();
      waited++;
    end
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic drain(output int cycles);
    flush_i = 1'b1; cycles = 0;
    #1;
    while (busy_o && cycles < 64) begin
      tick();
      cycles++;
    end
    flush_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    tests_run++;
    if (req_ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_low got %b want 0", req_ready_o); end
    for (int w = 0; w < int'(NWORDS); w++) begin
      load_en = 1'b1; load_word = 5'(w); load_val = {$urandom, $urandom};
      tick();
    end
    load_en = 1'b0;
    resync_en = 1'b1;
    tick();
    resync_en = 1'b0;
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (req_ready_o !== 1'b1) begin tests_failed++; $display("FAIL post_reset_ready got %b want 1", req_ready_o); end
    tests_run++;
    if ({rf_we_o, rf_re_o, busy_o} !== 3'b000) begin tests_failed++; $display("FAIL reset_strobes got we=%b re=%b busy=%b want 0", rf_we_o, rf_re_o, busy_o); end
    tests_run++;
    if ({rf_waddr_o, rf_wdata_o, rf_raddr_o} !== '0) begin tests_failed++; $display("FAIL reset_addr_data got waddr=%h wdata=%h raddr=%h want 0", rf_waddr_o, rf_wdata_o, rf_raddr_o); end
  endtask

  task automatic test_pair();
    int w0, w1, re0;
    re0 = n_re;
    send(6'h0A, 32'h11111111, w0);
    send(6'h0B, 32'h22222222, w1);
    tests_run++;
    if (w1 !== 0) begin tests_failed++; $display("FAIL pair_ready_wait got %0d want 0", w1); end
    tests_run++;
    if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd5 || rf_wdata_o !== 64'h22222222_11111111) begin
      tests_failed++; $display("FAIL pair_write got we=%b waddr=%0d wdata=%h want 1/5/2222222211111111", rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    tests_run++;
    if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL pair_busy_during_we got %b want 1", busy_o); end
    tick();
    tests_run++;
    if (rf_we_o !== 1'b0 || busy_o !== 1'b0) begin tests_failed++; $display("FAIL pair_single_pulse got we=%b busy=%b want 0/0", rf_we_o, busy_o); end
    tests_run++;
    if (n_re !== re0) begin tests_failed++; $display("FAIL pair_no_read got %0d reads want 0", n_re - re0); end
  endtask

  task automatic test_timeout();
    int w, hold;
    load_word_val(5'd5, 64'hDEADBEEF_CAFEF00D);
    send(6'h0A, 32'hAAAA0000, w);
    tests_run++;
    if (busy_o !== 1'b1 || rf_re_o !== 1'b0) begin tests_failed++; $display("FAIL hold_busy got busy=%b re=%b want 1/0", busy_o, rf_re_o); end
    hold = 0;
    while (!rf_re_o && hold < 64) begin
      tick();
      hold++;
    end
    tests_run++;
    if (hold !== int'(HOLD_TIMEOUT)) begin tests_failed++; $display("FAIL timeout_hold_cycles got %0d want %0d", hold, HOLD_TIMEOUT); end
    tests_run++;
    if (rf_raddr_o !== 6'h0B) begin tests_failed++; $display("FAIL timeout_raddr got %h want 0b", rf_raddr_o); end
    tick();
    tests_run++;
    if (rf_re_o !== 1'b0 || req_ready_o !== 1'b0) begin tests_failed++; $display("FAIL merge_state got re=%b ready=%b want 0/0", rf_re_o, req_ready_o); end
    tick();
    tests_run++;
    if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd5 || rf_wdata_o !== 64'hDEADBEEF_AAAA0000) begin
      tests_failed++; $display("FAIL rmw_write got we=%b waddr=%0d wdata=%h want 1/5/deadbeefaaaa0000", rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    tick();
  endtask

  task automatic test_conflict();
    int w, w2, we0, dc;
    logic [31:0] exp_hi;
    send(6'h04, 32'h00000001, w);
    exp_hi = rf_mem[2][63:32];
    we0 = n_we;
    send(6'h07, 32'h12345678, w2);
    tests_run++;
    if (w2 !== 3) begin tests_failed++; $display("FAIL conflict_ready_low_cycles got %0d want 3", w2); end
    tests_run++;
    if (n_we - we0 !== 1 || last_waddr !== 5'd2 || last_wdata !== {exp_hi, 32'h00000001}) begin
      tests_failed++; $display("FAIL conflict_rmw got n=%0d waddr=%0d wdata=%h want 1/2/%h00000001", n_we - we0, last_waddr, last_wdata, exp_hi);
    end
    drain(dc);
    tests_run++;
    if (dc >= 64) begin tests_failed++; $display("FAIL conflict_drain_timeout got %0d cycles want <64", dc); end
  endtask

  task automatic test_overwrite();
    int w, re0;
    re0 = n_re;
    send(6'h03, 32'h5, w);
    send(6'h03, 32'h6, w);
    send(6'h02, 32'h7, w);
    tests_run++;
    if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd1 || rf_wdata_o !== 64'h00000006_00000007) begin
      tests_failed++; $display("FAIL overwrite_write got we=%b waddr=%0d wdata=%h want 1/1/0000000600000007", rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    tests_run++;
    if (n_re !== re0) begin tests_failed++; $display("FAIL overwrite_no_read got %0d reads want 0", n_re - re0); end
    tick();
  endtask

  task automatic test_reset_mid_rd();
    int w, we0;
    send(6'h08, $urandom, w);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    tests_run++;
    if (rf_re_o !== 1'b1 || rf_raddr_o !== 6'h09) begin tests_failed++; $display("FAIL flush_to_rd got re=%b raddr=%h want 1/09", rf_re_o, rf_raddr_o); end
    we0 = n_we;
    rst_n = 1'b0;
    tick();
    tests_run++;
    if ({req_ready_o, rf_we_o, rf_re_o, busy_o, rf_waddr_o, rf_wdata_o, rf_raddr_o} !== '0) begin
      tests_failed++; $display("FAIL mid_rd_reset_outputs got ready=%b we=%b re=%b busy=%b waddr=%h wdata=%h raddr=%h want 0",
                               req_ready_o, rf_we_o, rf_re_o, busy_o, rf_waddr_o, rf_wdata_o, rf_raddr_o);
    end
    rst_n = 1'b1;
    tick(); tick(); tick();
    tests_run++;
    if (n_we !== we0 || busy_o !== 1'b0 || req_ready_o !== 1'b1) begin
      tests_failed++; $display("FAIL mid_rd_abort got writes=%0d busy=%b ready=%b want 0/0/1", n_we - we0, busy_o, req_ready_o);
    end
    resync_en = 1'b1;
    tick();
    resync_en = 1'b0;
  endtask

`ifdef RF_WRITE_PACKER_STATS_EN
  task automatic test_stats();
    int w, dc;
    stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0;
    send(6'h10, $urandom, w); send(6'h11, $urandom, w);
    send(6'h13, $urandom, w); send(6'h12, $urandom, w);
    send(6'h15, $urandom, w); send(6'h14, $urandom, w);
    send(6'h20, $urandom, w); drain(dc);
    send(6'h23, $urandom, w); drain(dc);
    tick();
    tests_run++;
    if (stat_pair_o !== 16'd3 || stat_rmw_o !== 16'd2) begin
      tests_failed++; $display("FAIL stats_counts got pair=%0d rmw=%0d want 3/2", stat_pair_o, stat_rmw_o);
    end
    stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0;
    tests_run++;
    if (stat_pair_o !== 16'd0 || stat_rmw_o !== 16'd0) begin
      tests_failed++; $display("FAIL stats_clear got pair=%0d rmw=%0d want 0/0", stat_pair_o, stat_rmw_o);
    end
  endtask
`endif

  task automatic test_random();
    int dc;
    for (int c = 0; c < 600; c++) begin
      req_valid_i = ($urandom_range(0, 9) < 6);
      req_addr_i  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      req_data_i  = $urandom;
      flush_i     = !req_valid_i && ($urandom_range(0, 19) == 0);
      tick();
    end
    req_valid_i = 1'b0;
    drain(dc);
    tick();
    tests_run++;
    if (dc >= 64) begin tests_failed++; $display("FAIL random_drain_timeout got %0d cycles want <64", dc); end
    for (int i = 0; i < int'(NWORDS); i++) begin
      tests_run++;
      if (rf_mem[i] !== {ideal[2*i+1], ideal[2*i]}) begin
        tests_failed++; $display("FAIL random_word_%0d got %h want %h", i, rf_mem[i], {ideal[2*i+1], ideal[2*i]});
      end
    end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_timeout();
    test_conflict();
    test_overwrite();
    test_reset_mid_rd();
`ifdef RF_WRITE_PACKER_STATS_EN
    test_stats();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
